// File: rtl/fpu_sequencer_pkg.sv
// fpu_sequencer_pkg: opcodes, response flag bit positions and FSM states for the fpu sequencer
package fpu_sequencer_pkg;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_SQRT = 3'd3;
    localparam logic [2:0] OP_CMP  = 3'd4;
    localparam int F_OV      = 0;
    localparam int F_UN      = 1;
    localparam int F_INV     = 2;
    localparam int F_INEXACT = 3;
    localparam int F_DIVZ    = 4;
    localparam int F_LESS    = 5;
    localparam int F_EQ      = 6;
    localparam int F_GREAT   = 7;
    localparam int F_TIMEOUT = 8;
    localparam int F_ILLEGAL = 9;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_CAPTURE, S_RESP} state_t;
endpackage

// File: rtl/fpu_sequencer_if.sv
// fpu_sequencer_if: command and response handshake between the CPU shim and the sequencer
interface fpu_sequencer_if #(parameter int TAG_W = 4) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [2:0]       cmd_rm;
    logic [TAG_W-1:0] cmd_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [9:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    modport master (output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_rm, cmd_tag, rsp_ready,
                    input  cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag);
    modport slave  (input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_rm, cmd_tag, rsp_ready,
                    output cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag);
endinterface

// File: rtl/fpu_sequencer_cmd_fifo.sv
// fpu_cmd_fifo: command queue with wrap-bit pointers so full and empty are distinguishable
module fpu_cmd_fifo #(
    parameter int W     = 74,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];
    // advance pointers; a push while full is dropped, the caller gates it with ready
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
    // storage needs no reset: entries are only read once written
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: queues fpu commands and runs them one at a time, returning tagged responses
module fpu_sequencer
    import fpu_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int TIMEOUT    = 64,
    parameter int MIN_LAT    = 1
) (
    input  logic        clk,
    input  logic        rstn,
    fpu_sequencer_if.slave bus,
    output logic [31:0] fpu_in1,
    output logic [31:0] fpu_in2,
    output logic [2:0]  fpu_opcode,
    output logic [2:0]  fpu_round,
    output logic        fpu_act,
    output logic        fpu_rstp,
    input  logic [31:0] fpu_out,
    input  logic        fpu_ov,
    input  logic        fpu_un,
    input  logic        fpu_inv,
    input  logic        fpu_inexact,
    input  logic        fpu_div_zero,
    input  logic        fpu_less,
    input  logic        fpu_eq,
    input  logic        fpu_great,
    input  logic        fpu_done,
    output logic        busy
);
    localparam int W  = 3 + 32 + 32 + 3 + TAG_W;
    localparam int CW = $clog2(TIMEOUT);
    state_t           state, next;
    logic [CW-1:0]    cnt;
    logic             up, full, empty, pop, done_ok, tmo, hold;
    logic [W-1:0]     head;
    logic [2:0]       op, rm;
    logic [31:0]      a, b, res;
    logic [TAG_W-1:0] tag;
    logic [9:0]       flags;

    fpu_cmd_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (bus.cmd_valid && bus.cmd_ready),
        .din   ({bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_rm, bus.cmd_tag}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.cmd_ready  = up && !full;
    assign bus.rsp_valid  = state == S_RESP;
    assign bus.rsp_result = res;
    assign bus.rsp_flags  = flags;
    assign bus.rsp_tag    = tag;
    assign done_ok        = fpu_done && cnt >= CW'(MIN_LAT);
    assign tmo            = cnt == CW'(TIMEOUT - 1);
    assign hold           = state inside {S_CLEAR, S_RUN, S_CAPTURE};
    assign fpu_in1        = hold ? a : '0;
    assign fpu_in2        = hold ? b : '0;
    assign fpu_opcode     = hold ? op : '0;
    assign fpu_round      = hold ? rm : '0;
    assign fpu_act        = state == S_RUN;
    assign fpu_rstp       = state == S_CLEAR;
    assign busy           = state != S_IDLE || !empty;

    // next state and FIFO pop; a done before MIN_LAT is treated as stale and ignored
    always_comb begin
        next = state;
        pop  = 1'b0;
        case (state)
            S_IDLE: if (!empty) begin
                pop  = 1'b1;
                next = head[W-1 -: 3] <= OP_CMP ? S_CLEAR : S_RESP;
            end
            S_CLEAR:   next = S_RUN;
            S_RUN:     next = done_ok ? S_CAPTURE : tmo ? S_RESP : S_RUN;
            S_CAPTURE: next = S_RESP;
            S_RESP:    next = bus.rsp_ready ? S_IDLE : S_RESP;
            default:   next = S_IDLE;
        endcase
    end

    // state register; cmd_ready is held off until the first edge after reset release
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            up    <= 1'b0;
        end else begin
            state <= next;
            up    <= 1'b1;
        end
    end

    // RUN cycle counter, zero on entry to RUN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt <= '0;
        else       cnt <= state == S_RUN ? cnt + 1'b1 : '0;
    end

    // popped command held for the whole operation and for the response tag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) {op, a, b, rm, tag} <= '0;
        else if (pop) {op, a, b, rm, tag} <= head;
    end

    // response payload: illegal and timeout carry a zero result, compare keeps only relation flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res   <= '0;
            flags <= '0;
        end else if (state == S_IDLE && next == S_RESP) begin
            res   <= '0;
            flags <= 10'(1) << F_ILLEGAL;
        end else if (state == S_RUN && next == S_RESP) begin
            res   <= '0;
            flags <= 10'(1) << F_TIMEOUT;
        end else if (state == S_CAPTURE) begin
            res   <= op == OP_CMP ? '0 : fpu_out;
            flags <= op == OP_CMP ? {2'b00, fpu_great, fpu_eq, fpu_less, 2'b00, fpu_inv, 2'b00}
                                  : {5'b00000, fpu_div_zero, fpu_inexact, fpu_inv, fpu_un, fpu_ov};
        end
    end
endmodule
